// File: rtl/rv_encoder_pkg.sv
// rv_encoder_pkg
//   Shared types and the combinational RV32I encoder used by rv_instr_encoder.
//   Contents: kind_t descriptor kinds, FSM state_t, opcode constants,
//   desc_t input descriptor, enc_t encoder result, encode_instr().
//   Optional feature macro: IMM_RANGE_CHECK_EN. When defined, the encoder
//   also flags immediates that do not sign-fit their format and misaligned
//   BR/JAL offsets. The truncated word is produced either way.
package rv_encoder_pkg;

  typedef enum logic [3:0] {
    K_R     = 4'd0,
    K_I_ALU = 4'd1,
    K_LW    = 4'd2,
    K_SW    = 4'd3,
    K_BR    = 4'd4,
    K_JAL   = 4'd5,
    K_JALR  = 4'd6,
    K_LUI   = 4'd7,
    K_HALT  = 4'd8
  } kind_t;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_DRAIN  = 2'd1,
    S_SEALED = 2'd2
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_HALT  = 7'b1000000;

  localparam logic [31:0] HALT_WORD = {25'd0, OP_HALT};

  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } enc_t;

  // True when v[31:msb] are all copies of the sign bit, i.e. v fits in msb+1 signed bits.
  function automatic logic sign_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

  function automatic enc_t encode_instr(input desc_t d);
    enc_t       e;
    logic [11:0] imm_i;
    logic        shift_op;
    e.word   = 32'd0;
    e.err    = 1'b0;
    shift_op = (d.funct3 == 3'b001) || (d.funct3 == 3'b101);
    // Shift-immediates carry funct7 in the upper immediate bits.
    imm_i    = shift_op ? {d.funct7, d.imm[4:0]} : d.imm[11:0];
    case (d.kind)
      K_R:     e.word = {d.funct7, d.rs2, d.rs1, d.funct3, d.rd, OP_R};
      K_I_ALU: e.word = {imm_i, d.rs1, d.funct3, d.rd, OP_I_ALU};
      K_LW:    e.word = {d.imm[11:0], d.rs1, 3'b010, d.rd, OP_LW};
      K_SW:    e.word = {d.imm[11:5], d.rs2, d.rs1, 3'b010, d.imm[4:0], OP_SW};
      K_BR:    e.word = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, d.funct3,
                         d.imm[4:1], d.imm[11], OP_BR};
      K_JAL:   e.word = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], d.rd, OP_JAL};
      K_JALR:  e.word = {d.imm[11:0], d.rs1, 3'b000, d.rd, OP_JALR};
      K_LUI:   e.word = {d.imm[31:12], d.rd, OP_LUI};
      K_HALT:  e.word = HALT_WORD;
      default: e.err  = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (d.kind)
      K_I_ALU, K_LW, K_JALR, K_SW: if (!sign_fits(d.imm, 11)) e.err = 1'b1;
      K_BR:  if (!sign_fits(d.imm, 12) || d.imm[0]) e.err = 1'b1;
      K_JAL: if (!sign_fits(d.imm, 20) || d.imm[0]) e.err = 1'b1;
      default: ;
    endcase
`endif
    return e;
  endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// rv_instr_encoder_if
//   Descriptor handshake plus instruction-memory write bus.
//   slave  : encoder side (takes descriptors, drives memory writes)
//   master : driver side (offers descriptors, models memory stall)
//   Parameter ADDR_W sets the memory word-address width.
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              mem_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  mem_stall,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output mem_stall,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_instr_fifo.sv
// rv_instr_fifo
//   Synchronous FIFO for encoded words.
//   Ports: clk, reset (sync, active-high), push/din, pop/dout (head, show-ahead),
//   full, empty. Push while full and pop while empty are ignored.
//   DEPTH must be a power of two >= 2.
module rv_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
//   Encodes RV32I descriptors into instruction words, buffers them and writes
//   them to consecutive instruction-memory addresses. A HALT descriptor closes
//   the program; once it is written (or the last address is used) the block
//   seals until reset.
//   Ports: clk, reset (sync, active-high), bus (rv_instr_encoder_if.slave:
//   descriptor handshake + memory write), words_o (words written),
//   sealed_o, err_o (sticky encoding/exhaustion error).
//   Optional feature macro: IMM_RANGE_CHECK_EN (see rv_encoder_pkg).
//
//   state    | meaning
//   S_LOAD   | accepting descriptors, writing buffered words
//   S_DRAIN  | HALT accepted; flushing buffer up to and including HALT
//   S_SEALED | no accepts, no writes; left only by reset
module rv_instr_encoder
  import rv_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 9,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  rv_instr_encoder_if.slave   bus,
  output logic [ADDR_W:0]     words_o,
  output logic                sealed_o,
  output logic                err_o
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  desc_t             desc;
  enc_t              enc;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_last;

  assign desc = '{kind:   bus.in_kind,
                  funct3: bus.in_funct3,
                  funct7: bus.in_funct7,
                  rd:     bus.in_rd,
                  rs1:    bus.in_rs1,
                  rs2:    bus.in_rs2,
                  imm:    bus.in_imm};
  assign enc  = encode_instr(desc);

  assign bus.in_ready  = (state == S_LOAD) && !fifo_full;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.mem_we    = !fifo_empty && !bus.mem_stall && (state != S_SEALED);
  // Stale storage is hidden while empty so the bus reads zero after reset.
  assign bus.mem_wdata = fifo_empty ? 32'd0 : head;
  assign bus.mem_addr  = addr_q;
  assign wr_last       = bus.mem_we && (addr_q == LAST_ADDR);
  assign sealed_o      = (state == S_SEALED);

  rv_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (bus.mem_we),
    .din   (enc.word),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (wr_last)                              state_nxt = S_SEALED;
        else if (accept && desc.kind == K_HALT)   state_nxt = S_DRAIN;
      end
      // HALT is the only word with opcode 1000000, so seeing it on the bus
      // marks the end of the drain.
      S_DRAIN: begin
        if (wr_last || (bus.mem_we && bus.mem_wdata == HALT_WORD))
          state_nxt = S_SEALED;
      end
      S_SEALED: state_nxt = S_SEALED;
      default:  state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= ADDR_W'(BASE_ADDR);
      words_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (bus.mem_we) begin
        words_o <= words_o + (ADDR_W+1)'(1);
        // The address never wraps; the last write seals the block instead.
        if (addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
      end
      if ((accept && enc.err) || wr_last) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
module tb_rv_instr_encoder;
  import rv_encoder_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } vin_t;

  typedef struct packed {
    vin_t        in;
    logic [31:0] word;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        valid1 = 1'b0, valid2 = 1'b0, stall1 = 1'b0;
  logic [3:0]  d_kind = '0;
  logic [2:0]  d_f3 = '0;
  logic [6:0]  d_f7 = '0;
  logic [4:0]  d_rd = '0, d_rs1 = '0, d_rs2 = '0;
  logic [31:0] d_imm = '0;

  rv_instr_encoder_if #(.ADDR_W(9)) bus1();
  rv_instr_encoder_if #(.ADDR_W(2)) bus2();

  assign bus1.in_valid = valid1;    assign bus2.in_valid = valid2;
  assign bus1.in_kind = d_kind;     assign bus2.in_kind = d_kind;
  assign bus1.in_funct3 = d_f3;     assign bus2.in_funct3 = d_f3;
  assign bus1.in_funct7 = d_f7;     assign bus2.in_funct7 = d_f7;
  assign bus1.in_rd = d_rd;         assign bus2.in_rd = d_rd;
  assign bus1.in_rs1 = d_rs1;       assign bus2.in_rs1 = d_rs1;
  assign bus1.in_rs2 = d_rs2;       assign bus2.in_rs2 = d_rs2;
  assign bus1.in_imm = d_imm;       assign bus2.in_imm = d_imm;
  assign bus1.mem_stall = stall1;   assign bus2.mem_stall = 1'b0;

  logic [9:0] words1;
  logic       sealed1, err1;
  logic [2:0] words2;
  logic       sealed2, err2;

  rv_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(9), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .bus(bus1),
    .words_o(words1), .sealed_o(sealed1), .err_o(err1)
  );

  rv_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) u_dut_small (
    .clk(clk), .reset(reset), .bus(bus2),
    .words_o(words2), .sealed_o(sealed2), .err_o(err2)
  );

  wr_t wq1[$];
  wr_t wq2[$];

  always @(negedge clk) begin
    if (bus1.mem_we) wq1.push_back('{addr: bus1.mem_addr, data: bus1.mem_wdata});
    if (bus2.mem_we) wq2.push_back('{addr: 9'(bus2.mem_addr), data: bus2.mem_wdata});
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vin_t mk(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    return '{kind: k, f3: f3, f7: f7, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
  endfunction

  // add x<rd>,x1,x2
  function automatic logic [31:0] add_word(input logic [4:0] rd);
    return 32'h0020_8033 | (32'(rd) << 7);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wq1.delete();
    wq2.delete();
  endtask

  task automatic send(input int which, input vin_t v);
    logic ok;
    d_kind = v.kind; d_f3 = v.f3; d_f7 = v.f7;
    d_rd = v.rd; d_rs1 = v.rs1; d_rs2 = v.rs2; d_imm = v.imm;
    if (which == 1) valid1 = 1'b1; else valid2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((which == 1) ? bus1.in_ready : bus2.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1;
    valid1 = 1'b0; valid2 = 1'b0;
    chk("send_accepted", 64'(ok), 64'(1));
  endtask

  task automatic wait_writes(input int which, input int n);
    for (int i = 0; i < 60; i++) begin
      if (((which == 1) ? wq1.size() : wq2.size()) >= n) break;
      @(negedge clk);
    end
    chk("write_count", 64'((which == 1) ? wq1.size() : wq2.size()), 64'(n));
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 64'(bus1.in_ready), 64'(1));
    chk("rst_mem_we",   64'(bus1.mem_we), 64'(0));
    chk("rst_mem_addr", 64'(bus1.mem_addr), 64'(0));
    chk("rst_wdata",    64'(bus1.mem_wdata), 64'(0));
    chk("rst_words",    64'(words1), 64'(0));
    chk("rst_sealed",   64'(sealed1), 64'(0));
    chk("rst_err",      64'(err1), 64'(0));
  endtask

  vec_t tv[12];

  initial begin
    tv[0]  = '{in: mk(K_R,     3'b000, 7'h00, 5'd3,  5'd1, 5'd2, 32'd0),          word: 32'h0020_81B3, err: 1'b0};
    tv[1]  = '{in: mk(K_I_ALU, 3'b000, 7'h00, 5'd5,  5'd0, 5'd0, 32'hFFFF_FFFF),  word: 32'hFFF0_0293, err: 1'b0};
    tv[2]  = '{in: mk(K_LW,    3'b000, 7'h00, 5'd6,  5'd2, 5'd0, 32'd8),          word: 32'h0081_2303, err: 1'b0};
    tv[3]  = '{in: mk(K_BR,    3'b000, 7'h00, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC),  word: 32'hFE20_8EE3, err: 1'b0};
    tv[4]  = '{in: mk(K_SW,    3'b000, 7'h00, 5'd0,  5'd2, 5'd5, 32'd12),         word: 32'h0051_2623, err: 1'b0};
    tv[5]  = '{in: mk(K_JAL,   3'b000, 7'h00, 5'd1,  5'd0, 5'd0, 32'd8),          word: 32'h0080_00EF, err: 1'b0};
    tv[6]  = '{in: mk(K_JALR,  3'b111, 7'h00, 5'd0,  5'd1, 5'd0, 32'd0),          word: 32'h0000_8067, err: 1'b0};
    tv[7]  = '{in: mk(K_LUI,   3'b000, 7'h00, 5'd10, 5'd0, 5'd0, 32'h1234_5000),  word: 32'h1234_5537, err: 1'b0};
    tv[8]  = '{in: mk(K_I_ALU, 3'b101, 7'h20, 5'd7,  5'd8, 5'd0, 32'hFFFF_FFE3),  word: 32'h4034_5393, err: 1'b0};
    tv[9]  = '{in: mk(4'd12,   3'b000, 7'h00, 5'd1,  5'd1, 5'd1, 32'd0),          word: 32'h0000_0000, err: 1'b1};
    tv[10] = '{in: mk(K_JAL,   3'b000, 7'h00, 5'd0,  5'd0, 5'd0, 32'h0010_0000),  word: 32'h8000_006F, err: RC};
    tv[11] = '{in: mk(K_BR,    3'b000, 7'h00, 5'd0,  5'd1, 5'd2, 32'd3),          word: 32'h0020_8163, err: RC};

    do_reset();
    chk_reset_vals();

    // Single-descriptor encodings, each from a fresh reset.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      send(1, tv[i].in);
      wait_writes(1, 1);
      chk($sformatf("vec%0d_word", i), 64'(wq1[0].data), 64'(tv[i].word));
      chk($sformatf("vec%0d_addr", i), 64'(wq1[0].addr), 64'(0));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_err", i), 64'(err1), 64'(tv[i].err));
      chk($sformatf("vec%0d_words", i), 64'(words1), 64'(1));
    end

    // Back-to-back addi / lw land at consecutive addresses.
    do_reset();
    send(1, tv[1].in);
    send(1, tv[2].in);
    wait_writes(1, 2);
    chk("pair_w0", 64'(wq1[0].data), 64'(32'hFFF0_0293));
    chk("pair_w1", 64'(wq1[1].data), 64'(32'h0081_2303));
    chk("pair_a1", 64'(wq1[1].addr), 64'(1));
    @(posedge clk); #1;
    chk("pair_words", 64'(words1), 64'(2));

    // Stall: buffer fills, head and address hold, then drains in order.
    do_reset();
    stall1 = 1'b1;
    for (int k = 0; k < 4; k++) send(1, mk(K_R, 3'b000, 7'h00, 5'(k + 1), 5'd1, 5'd2, 32'd0));
    @(negedge clk);
    chk("stall_in_ready", 64'(bus1.in_ready), 64'(0));
    chk("stall_we", 64'(bus1.mem_we), 64'(0));
    chk("stall_addr", 64'(bus1.mem_addr), 64'(0));
    chk("stall_head", 64'(bus1.mem_wdata), 64'(add_word(5'd1)));
    d_rd = 5'd5; valid1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_5th_blocked", 64'(bus1.in_ready), 64'(0));
    valid1 = 1'b0;
    chk("stall_no_writes", 64'(wq1.size()), 64'(0));
    @(posedge clk); #1 stall1 = 1'b0;
    wait_writes(1, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_addr", k), 64'(wq1[k].addr), 64'(k));
      chk($sformatf("drain%0d_data", k), 64'(wq1[k].data), 64'(add_word(5'(k + 1))));
    end
    @(negedge clk);
    chk("drain_in_ready", 64'(bus1.in_ready), 64'(1));
    send(1, mk(K_R, 3'b000, 7'h00, 5'd5, 5'd1, 5'd2, 32'd0));
    wait_writes(1, 5);
    chk("fifth_addr", 64'(wq1[4].addr), 64'(4));
    chk("fifth_data", 64'(wq1[4].data), 64'(add_word(5'd5)));

    // HALT after two words seals the block.
    do_reset();
    send(1, mk(K_R, 3'b000, 7'h00, 5'd1, 5'd1, 5'd2, 32'd0));
    send(1, mk(K_R, 3'b000, 7'h00, 5'd2, 5'd1, 5'd2, 32'd0));
    send(1, mk(K_HALT, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0));
    @(negedge clk);
    chk("halt_in_ready", 64'(bus1.in_ready), 64'(0));
    wait_writes(1, 3);
    chk("halt_word", 64'(wq1[2].data), 64'(32'h0000_0040));
    chk("halt_addr", 64'(wq1[2].addr), 64'(2));
    @(posedge clk); #1;
    chk("halt_sealed", 64'(sealed1), 64'(1));
    chk("halt_err", 64'(err1), 64'(0));
    d_kind = K_R; d_rd = 5'd9; valid1 = 1'b1;
    repeat (5) @(negedge clk);
    chk("sealed_in_ready", 64'(bus1.in_ready), 64'(0));
    valid1 = 1'b0;
    @(negedge clk);
    chk("sealed_no_write", 64'(wq1.size()), 64'(3));
    chk("sealed_words", 64'(words1), 64'(3));

    // Address exhaustion on the 2-bit-address instance.
    do_reset();
    for (int k = 0; k < 4; k++) send(2, mk(K_R, 3'b000, 7'h00, 5'(k + 1), 5'd1, 5'd2, 32'd0));
    wait_writes(2, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("small%0d_addr", k), 64'(wq2[k].addr), 64'(k));
    @(posedge clk); #1;
    chk("small_sealed", 64'(sealed2), 64'(1));
    chk("small_err", 64'(err2), 64'(1));
    chk("small_words", 64'(words2), 64'(4));
    valid2 = 1'b1;
    repeat (4) @(negedge clk);
    chk("small_in_ready", 64'(bus2.in_ready), 64'(0));
    valid2 = 1'b0;
    chk("small_no_more", 64'(wq2.size()), 64'(4));

    // Reset with three buffered words drops them.
    do_reset();
    stall1 = 1'b1;
    for (int k = 0; k < 3; k++) send(1, mk(K_R, 3'b000, 7'h00, 5'(k + 1), 5'd1, 5'd2, 32'd0));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    stall1 = 1'b0;
    wq1.delete();
    chk_reset_vals();
    repeat (10) @(negedge clk);
    chk("midrst_no_write", 64'(wq1.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
